// File: rtl/gol_board_ctrl.sv
// Game-of-life board controller: serial seed load, cell-array priming,
// bounded generation runs with pause and extinction detection.
module gol_board_ctrl #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int GEN_W  = 16,
  localparam int N     = WIDTH * HEIGHT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_valid,
  output logic             seed_ready,
  input  logic             seed_bit,
  input  logic             start,
  input  logic [GEN_W-1:0] num_gens,
  input  logic             pause,
  input  logic             reload,
  input  logic [N-1:0]     board_state,
  output logic [N-1:0]     init_state,
  output logic             cell_rst,
  output logic             step_en,
  output logic             busy,
  output logic             done,
  output logic [GEN_W-1:0] gen_count,
  output logic             extinct
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    LOAD, PRIME, READY, RUN, FIN
  } state_t;

  state_t           state;
  logic [CW-1:0]    bit_cnt;
  logic [GEN_W-1:0] num_q;
  logic [GEN_W-1:0] gen_next;
  logic             alive;

  assign alive    = |board_state;
  assign gen_next = gen_count + GEN_W'(1);

  assign seed_ready = (state == LOAD);
  assign busy       = (state == PRIME) || (state == RUN);
  assign done       = (state == FIN);
  assign step_en    = (state == RUN) && alive && !pause;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= LOAD;
      bit_cnt    <= '0;
      init_state <= '0;
      cell_rst   <= 1'b0;
      num_q      <= '0;
      gen_count  <= '0;
      extinct    <= 1'b0;
    end else begin
      unique case (state)
        LOAD: begin
          if (seed_valid) begin
            init_state[bit_cnt] <= seed_bit;
            if (bit_cnt == CW'(N - 1)) begin
              bit_cnt  <= '0;
              cell_rst <= 1'b0;
              state    <= PRIME;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
        end
        PRIME: begin
          cell_rst <= 1'b1;
          state    <= READY;
        end
        READY: begin
          if (reload) begin
            bit_cnt <= '0;
            state   <= LOAD;
          end else if (start) begin
            num_q     <= num_gens;
            gen_count <= '0;
            extinct   <= 1'b0;
            state     <= (num_gens == '0) ? FIN : RUN;
          end
        end
        RUN: begin
          // extinction outranks pause so a dead board never stalls
          if (!alive) begin
            extinct <= 1'b1;
            state   <= FIN;
          end else if (!pause) begin
            gen_count <= gen_next;
            if (gen_next == num_q) state <= FIN;
          end
        end
        FIN: state <= READY;
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_gol_board_ctrl.sv
// Bench for gol_board_ctrl: behavioural cell array, seed and run
// scoreboards popped by a negedge monitor.
module tb_gol_board_ctrl;

  localparam int W = 8;
  localparam int H = 8;
  localparam int G = 16;
  localparam int N = W * H;

  logic         clk = 0;
  logic         rst = 0;
  logic         seed_valid = 0;
  logic         seed_ready;
  logic         seed_bit = 0;
  logic         start = 0;
  logic [G-1:0] num_gens = '0;
  logic         pause = 0;
  logic         reload = 0;
  logic [N-1:0] board = '0;
  logic [N-1:0] init_state;
  logic         cell_rst;
  logic         step_en;
  logic         busy;
  logic         done;
  logic [G-1:0] gen_count;
  logic         extinct;

  gol_board_ctrl #(.WIDTH(W), .HEIGHT(H), .GEN_W(G)) dut (
    .clk(clk), .rst(rst),
    .seed_valid(seed_valid), .seed_ready(seed_ready),
    .seed_bit(seed_bit), .start(start), .num_gens(num_gens),
    .pause(pause), .reload(reload), .board_state(board),
    .init_state(init_state), .cell_rst(cell_rst),
    .step_en(step_en), .busy(busy), .done(done),
    .gen_count(gen_count), .extinct(extinct)
  );

  always #5 clk = ~clk;

  typedef struct {
    int gen;
    bit ext;
    int steps;
    int runc;
  } exp_t;

  exp_t         run_q[$];
  logic [N-1:0] seed_q[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] life(input logic [N-1:0] b);
    logic [N-1:0] n;
    int cnt;
    n = '0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < H &&
                c + dc >= 0 && c + dc < W && b[(r+dr)*W + c + dc])
              cnt++;
        n[r*W+c] = b[r*W+c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
      end
    return n;
  endfunction

  // behavioural cell array
  always @(posedge clk) begin
    if (!cell_rst) board <= init_state;
    else if (step_en) board <= life(board);
  end

  int steps = 0;
  int runc = 0;
  bit done_q = 0;

  always @(negedge clk) begin
    exp_t e;
    logic [N-1:0] s;
    if (!rst) begin
      steps = 0;
      runc = 0;
      done_q = 0;
    end else begin
      if (busy && cell_rst) runc++;
      if (step_en) steps++;
      chk("step_only_in_run", 64'(step_en && !(busy && cell_rst)), 0);
      if (busy && !cell_rst) begin
        if (seed_q.size() == 0) begin
          chk("unexpected_prime", 1, 0);
        end else begin
          s = seed_q.pop_front();
          chk("prime_init_state", init_state, s);
          chk("prime_seed_ready", 64'(seed_ready), 0);
        end
      end
      if (done) begin
        chk("done_one_cycle", 64'(done_q), 0);
        if (run_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = run_q.pop_front();
          chk("gen_count", 64'(gen_count), 64'(e.gen));
          chk("extinct", 64'(extinct), 64'(e.ext));
          chk("step_count", 64'(steps), 64'(e.steps));
          chk("run_cycles", 64'(runc), 64'(e.runc));
        end
        steps = 0;
        runc = 0;
      end
      done_q = done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_seed(input logic [N-1:0] s, input int nbits,
                           input bit gaps);
    if (nbits == N) seed_q.push_back(s);
    for (int i = 0; i < nbits; i++) begin
      if (gaps && (i % 3 == 1)) begin
        seed_valid = 0;
        seed_bit = ~s[i];
        start = 1;
        num_gens = 5;
        tick();
        start = 0;
      end
      seed_valid = 1;
      seed_bit = s[i];
      tick();
    end
    seed_valid = 0;
    seed_bit = 0;
  endtask

  task automatic do_start(input int n, input int gen, input bit ext,
                          input int st, input int rc);
    exp_t e;
    e.gen = gen;
    e.ext = ext;
    e.steps = st;
    e.runc = rc;
    run_q.push_back(e);
    start = 1;
    num_gens = G'(n);
    tick();
    start = 0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) chk("done_timeout", 1, 0);
    tick();
  endtask

  task automatic chk_reset_outs();
    chk("rst_init_state", init_state, 0);
    chk("rst_cell_rst", 64'(cell_rst), 0);
    chk("rst_seed_ready", 64'(seed_ready), 1);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_gen_count", 64'(gen_count), 0);
    chk("rst_extinct", 64'(extinct), 0);
    chk("rst_step_en", 64'(step_en), 0);
  endtask

  localparam logic [N-1:0] BLINK = 64'h0000_0000_0000_0E00;
  localparam logic [N-1:0] PAT6  = 64'h8000_0000_2070_4001;
  localparam logic [N-1:0] FULL  = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0;
    tick();
    tick();
    chk_reset_outs();
    rst = 1;

    // blinker load and prime
    send_seed(BLINK, N, 0);
    chk("prime_cell_rst", 64'(cell_rst), 0);
    tick();
    chk("ready_cell_rst", 64'(cell_rst), 1);
    chk("ready_init", init_state, BLINK);
    chk("ready_board", board, BLINK);

    // 4-generation run, step on first cycle after start
    do_start(4, 4, 0, 4, 4);
    chk("first_step_latency", 64'(step_en), 1);
    wait_done();

    // seed bits outside LOAD are dropped
    seed_valid = 1;
    seed_bit = 1;
    tick();
    tick();
    chk("ready_seed_ready", 64'(seed_ready), 0);
    seed_valid = 0;
    chk("ready_init_hold", init_state, BLINK);

    // pause 3 cycles with a reload ignored mid-run
    do_start(6, 6, 0, 6, 9);
    tick();
    pause = 1;
    tick();
    reload = 1;
    tick();
    reload = 0;
    tick();
    pause = 0;
    wait_done();

    // reload beats start in the same cycle
    reload = 1;
    start = 1;
    num_gens = 3;
    tick();
    reload = 0;
    start = 0;
    chk("reload_wins_ready", 64'(seed_ready), 1);
    chk("reload_wins_busy", 64'(busy), 0);

    // gapped load with start pulses during LOAD
    send_seed(PAT6, N, 1);
    tick();
    chk("gap_ready_board", board, PAT6);

    // all-zero seed: immediate extinction
    reload = 1;
    tick();
    reload = 0;
    send_seed('0, N, 0);
    tick();
    do_start(10, 0, 1, 0, 1);
    wait_done();
    chk("extinct_hold", 64'(extinct), 1);

    // zero generations clears extinct and finishes at once
    do_start(0, 0, 0, 0, 0);
    chk("zero_gen_done", 64'(done), 1);
    wait_done();

    // reset in the middle of a seed load
    reload = 1;
    tick();
    reload = 0;
    send_seed(64'hA5A5_A5A5_A5A5_A5A5, 20, 0);
    rst = 0;
    tick();
    rst = 1;
    chk_reset_outs();

    // full board dies in two generations
    send_seed(FULL, N, 0);
    tick();
    chk("new_seed_board", board, FULL);
    do_start(5, 2, 1, 2, 3);
    wait_done();

    tick();
    tick();
    chk("run_q_empty", 64'(run_q.size()), 0);
    chk("seed_q_empty", 64'(seed_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
